// File: rtl/wb_host_master.sv
// Command/response front end driving a single Wishbone classic transaction at a time.
// Optional bus timeout is compiled in with `define WB_HOST_TIMEOUT_EN.
module wb_host_master #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [3:0]  cmd_sel_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    if ((TIMEOUT_CYCLES < 32'd1) || (TIMEOUT_CYCLES > 32'd65535)) begin : g_bad_timeout
        $error("wb_host_master: TIMEOUT_CYCLES out of range 1..65535");
    end

    state_t      state_r;
    state_t      state_s;
    logic        cyc_r;
    logic        cyc_s;
    logic        stb_r;
    logic        stb_s;
    logic        we_r;
    logic        we_s;
    logic [3:0]  sel_r;
    logic [3:0]  sel_s;
    logic [31:0] adr_r;
    logic [31:0] adr_s;
    logic [31:0] dat_r;
    logic [31:0] dat_s;
    logic        rsp_valid_r;
    logic        rsp_valid_s;
    logic [31:0] rsp_dat_r;
    logic [31:0] rsp_dat_s;
    logic        rsp_err_r;
    logic        rsp_err_s;
    logic        tmo_hit_s;

`ifdef WB_HOST_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

    logic [15:0] tmo_cnt_r;

    // Counts completed STB cycles without ACK; zero whenever not waiting in BUS.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            tmo_cnt_r <= 16'd0;
        end else if ((state_r == ST_BUS) && !wbm_ack_i) begin
            tmo_cnt_r <= tmo_cnt_r + 16'd1;
        end else begin
            tmo_cnt_r <= 16'd0;
        end
    end

    // Expiry fires on the edge that would complete the TIMEOUT_CYCLES-th STB cycle.
    assign tmo_hit_s = (state_r == ST_BUS) && (tmo_cnt_r == TMO_LAST);
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Next-state and next-output decode for the transaction FSM.
    always_comb begin
        state_s     = state_r;
        cyc_s       = cyc_r;
        stb_s       = stb_r;
        we_s        = we_r;
        sel_s       = sel_r;
        adr_s       = adr_r;
        dat_s       = dat_r;
        rsp_valid_s = rsp_valid_r;
        rsp_dat_s   = rsp_dat_r;
        rsp_err_s   = rsp_err_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    cyc_s   = 1'b1;
                    stb_s   = 1'b1;
                    we_s    = cmd_we_i;
                    sel_s   = cmd_sel_i;
                    adr_s   = cmd_adr_i;
                    dat_s   = cmd_dat_i;
                    state_s = ST_BUS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUS: begin
                // ACK is checked first so it wins over a coincident timeout.
                if (wbm_ack_i) begin
                    cyc_s       = 1'b0;
                    stb_s       = 1'b0;
                    we_s        = 1'b0;
                    sel_s       = 4'h0;
                    adr_s       = 32'h0;
                    dat_s       = 32'h0;
                    rsp_dat_s   = we_r ? 32'h0 : wbm_dat_i;
                    rsp_err_s   = 1'b0;
                    rsp_valid_s = 1'b1;
                    state_s     = ST_RESP;
                end else if (tmo_hit_s) begin
                    cyc_s       = 1'b0;
                    stb_s       = 1'b0;
                    we_s        = 1'b0;
                    sel_s       = 4'h0;
                    adr_s       = 32'h0;
                    dat_s       = 32'h0;
                    rsp_dat_s   = 32'h0;
                    rsp_err_s   = 1'b1;
                    rsp_valid_s = 1'b1;
                    state_s     = ST_RESP;
                end else begin
                    state_s = ST_BUS;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_s = 1'b0;
                    state_s     = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                cyc_s       = 1'b0;
                stb_s       = 1'b0;
                we_s        = 1'b0;
                sel_s       = 4'h0;
                adr_s       = 32'h0;
                dat_s       = 32'h0;
                rsp_valid_s = 1'b0;
                state_s     = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transaction without a response.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_r     <= ST_IDLE;
            cyc_r       <= 1'b0;
            stb_r       <= 1'b0;
            we_r        <= 1'b0;
            sel_r       <= 4'h0;
            adr_r       <= 32'h0;
            dat_r       <= 32'h0;
            rsp_valid_r <= 1'b0;
            rsp_dat_r   <= 32'h0;
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            cyc_r       <= cyc_s;
            stb_r       <= stb_s;
            we_r        <= we_s;
            sel_r       <= sel_s;
            adr_r       <= adr_s;
            dat_r       <= dat_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_dat_r   <= rsp_dat_s;
            rsp_err_r   <= rsp_err_s;
        end
    end

    assign cmd_ready_o = (state_r == ST_IDLE);
    assign busy_o      = (state_r != ST_IDLE);
    assign wbm_cyc_o   = cyc_r;
    assign wbm_stb_o   = stb_r;
    assign wbm_we_o    = we_r;
    assign wbm_sel_o   = sel_r;
    assign wbm_adr_o   = adr_r;
    assign wbm_dat_o   = dat_r;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_dat_o   = rsp_dat_r;
    assign rsp_err_o   = rsp_err_r;

endmodule

// File: tb/tb_wb_host_master.sv
// Directed self-checking bench for wb_host_master with a programmable wait-state responder.
// Expectations follow WB_HOST_TIMEOUT_EN, which the bench sees the same way as the RTL.
module tb_wb_host_master;

    localparam int unsigned TMO = 8;

    logic        wb_clk_i;
    logic        wb_rst_ni;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [3:0]  cmd_sel_i;
    logic [31:0] cmd_adr_i;
    logic [31:0] cmd_dat_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;
    logic        busy_o;

    int   n_checks;
    int   n_errors;
    int   stb_cnt;
    int   wait_cnt;
    int   wait_req;
    logic resp_en;
    logic force_ack;

    wb_host_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_ni   (wb_rst_ni),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we_i),
        .cmd_sel_i   (cmd_sel_i),
        .cmd_adr_i   (cmd_adr_i),
        .cmd_dat_i   (cmd_dat_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_dat_o   (rsp_dat_o),
        .rsp_err_o   (rsp_err_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_ack_i   (wbm_ack_i),
        .wbm_dat_i   (wbm_dat_i),
        .busy_o      (busy_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    // Responder: ACK once STB has been waiting wait_req cycles.
    always @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wait_cnt <= 0;
        end else if (wbm_stb_o && !wbm_ack_i) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    assign wbm_ack_i = force_ack | (resp_en & wbm_cyc_o & wbm_stb_o & (wait_cnt == wait_req));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge wb_clk_i);
        if (wbm_stb_o) stb_cnt++;
    endtask

    task automatic send(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                        input logic [31:0] dat);
        cmd_we_i    = we;
        cmd_sel_i   = sel;
        cmd_adr_i   = adr;
        cmd_dat_i   = dat;
        cmd_valid_i = 1'b1;
        stb_cnt     = 0;
        step();
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int budget);
        int n;
        n = 0;
        while (!rsp_valid_o && (n < budget)) begin
            step();
            n++;
        end
        check(tag, 32'(rsp_valid_o), 32'd1);
    endtask

    task automatic handshake(input string tag);
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        check({tag, "_vld_clr"}, 32'(rsp_valid_o), 32'd0);
        check({tag, "_rdy"}, 32'(cmd_ready_o), 32'd1);
    endtask

    initial begin
        int stab_bad;
        int bp_bad;
        int seen_vld;
        int n;
        n_checks    = 0;
        n_errors    = 0;
        stb_cnt     = 0;
        wb_rst_ni   = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'b0;
        cmd_sel_i   = 4'h0;
        cmd_adr_i   = 32'h0;
        cmd_dat_i   = 32'h0;
        rsp_ready_i = 1'b0;
        wbm_dat_i   = 32'h0;
        resp_en     = 1'b1;
        force_ack   = 1'b0;
        wait_req    = 0;

        repeat (2) @(negedge wb_clk_i);
        check("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        check("rst_stb", 32'(wbm_stb_o), 32'd0);
        check("rst_adr", wbm_adr_o, 32'h0);
        check("rst_vld", 32'(rsp_valid_o), 32'd0);
        check("rst_dat", rsp_dat_o, 32'h0);
        check("rst_err", 32'(rsp_err_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        wb_rst_ni = 1'b1;
        step();
        check("rel_rdy", 32'(cmd_ready_o), 32'd1);

        // Zero-wait write: one STB cycle, response one edge after ACK, data forced to 0.
        wbm_dat_i = 32'hDEAD_BEEF;
        wait_req  = 0;
        send(1'b1, 4'hF, 32'h3000_0000, 32'h1234_5678);
        check("wr_cyc", 32'(wbm_cyc_o), 32'd1);
        check("wr_stb", 32'(wbm_stb_o), 32'd1);
        check("wr_we", 32'(wbm_we_o), 32'd1);
        check("wr_sel", 32'(wbm_sel_o), 32'hF);
        check("wr_adr", wbm_adr_o, 32'h3000_0000);
        check("wr_dat", wbm_dat_o, 32'h1234_5678);
        check("wr_rdy", 32'(cmd_ready_o), 32'd0);
        check("wr_busy", 32'(busy_o), 32'd1);
        step();
        check("wr_vld", 32'(rsp_valid_o), 32'd1);
        check("wr_stb_drop", 32'(wbm_stb_o), 32'd0);
        check("wr_cyc_drop", 32'(wbm_cyc_o), 32'd0);
        check("wr_adr_clr", wbm_adr_o, 32'h0);
        check("wr_wdat_clr", wbm_dat_o, 32'h0);
        check("wr_rdat", rsp_dat_o, 32'h0);
        check("wr_err", 32'(rsp_err_o), 32'd0);
        check("wr_stb_cycles", 32'(stb_cnt), 32'd1);
        handshake("wr");

        // Read with 3 wait states, then 5 cycles of backpressure with a queued command.
        wbm_dat_i = 32'hCAFE_F00D;
        wait_req  = 3;
        send(1'b0, 4'h6, 32'h3000_0004, 32'h5555_AAAA);
        stab_bad = 0;
        n = 0;
        while (!rsp_valid_o && (n < 20)) begin
            if (wbm_stb_o && !(wbm_cyc_o && !wbm_we_o && wbm_sel_o == 4'h6 &&
                wbm_adr_o == 32'h3000_0004 && wbm_dat_o == 32'h5555_AAAA)) stab_bad++;
            step();
            n++;
        end
        check("rd_vld", 32'(rsp_valid_o), 32'd1);
        check("rd_stable", 32'(stab_bad), 32'd0);
        check("rd_stb_cycles", 32'(stb_cnt), 32'd4);
        check("rd_dat", rsp_dat_o, 32'hCAFE_F00D);
        check("rd_err", 32'(rsp_err_o), 32'd0);
        wbm_dat_i   = 32'h0;
        cmd_we_i    = 1'b1;
        cmd_sel_i   = 4'h3;
        cmd_adr_i   = 32'h3000_0008;
        cmd_dat_i   = 32'h0BAD_F00D;
        cmd_valid_i = 1'b1;
        wait_req    = 0;
        bp_bad = 0;
        repeat (5) begin
            step();
            if (!(rsp_valid_o && rsp_dat_o == 32'hCAFE_F00D && !cmd_ready_o && busy_o &&
                !wbm_cyc_o)) bp_bad++;
        end
        check("bp_hold", 32'(bp_bad), 32'd0);
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        check("bp_vld_clr", 32'(rsp_valid_o), 32'd0);
        check("bp_rdy_next", 32'(cmd_ready_o), 32'd1);
        check("bp_no_pipe", 32'(wbm_cyc_o), 32'd0);
        step();
        cmd_valid_i = 1'b0;
        check("q_cyc", 32'(wbm_cyc_o), 32'd1);
        check("q_adr", wbm_adr_o, 32'h3000_0008);
        check("q_dat", wbm_dat_o, 32'h0BAD_F00D);
        step();
        check("q_vld", 32'(rsp_valid_o), 32'd1);
        handshake("q");

        // Stray ACK while idle must not start anything.
        force_ack = 1'b1;
        repeat (2) step();
        check("stray_busy", 32'(busy_o), 32'd0);
        check("stray_vld", 32'(rsp_valid_o), 32'd0);
        check("stray_cyc", 32'(wbm_cyc_o), 32'd0);
        force_ack = 1'b0;

        // ACK on the expiry edge (8th STB cycle) is a normal response.
        wbm_dat_i = 32'h1357_9BDF;
        wait_req  = int'(TMO) - 1;
        send(1'b0, 4'hF, 32'h3000_0010, 32'h0);
        wait_rsp("co_vld", 30);
        check("co_err", 32'(rsp_err_o), 32'd0);
        check("co_dat", rsp_dat_o, 32'h1357_9BDF);
        check("co_stb_cycles", 32'(stb_cnt), 32'(TMO));
        handshake("co");

        // Responder never ACKs.
        resp_en = 1'b0;
        send(1'b0, 4'hF, 32'h3000_000C, 32'h0);
`ifdef WB_HOST_TIMEOUT_EN
        n = 0;
        while (wbm_cyc_o && (n < 30)) begin
            step();
            n++;
        end
        check("to_cyc_drop", 32'(wbm_cyc_o), 32'd0);
        check("to_stb_cycles", 32'(stb_cnt), 32'(TMO));
        check("to_vld", 32'(rsp_valid_o), 32'd1);
        check("to_err", 32'(rsp_err_o), 32'd1);
        check("to_dat", rsp_dat_o, 32'h0);
        handshake("to");
`else
        seen_vld = 0;
        repeat (1000) begin
            step();
            if (rsp_valid_o || !wbm_stb_o) seen_vld++;
        end
        check("hang_stb_held", 32'(seen_vld), 32'd0);
        check("hang_stb_cycles", 32'(stb_cnt), 32'd1001);
        check("hang_err", 32'(rsp_err_o), 32'd0);
        wb_rst_ni = 1'b0;
        #1;
        check("hang_rst_cyc", 32'(wbm_cyc_o), 32'd0);
        repeat (2) @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        step();
        check("hang_rel_rdy", 32'(cmd_ready_o), 32'd1);
`endif
        resp_en = 1'b1;

        // Reset asserted during the 2nd wait cycle of a 5-wait transfer.
        wait_req = 5;
        send(1'b1, 4'hF, 32'h3000_0014, 32'hAAAA_5555);
        step();
        check("mid_pre_stb", 32'(wbm_stb_o), 32'd1);
        wb_rst_ni = 1'b0;
        #1;
        check("mid_cyc", 32'(wbm_cyc_o), 32'd0);
        check("mid_stb", 32'(wbm_stb_o), 32'd0);
        check("mid_adr", wbm_adr_o, 32'h0);
        check("mid_busy", 32'(busy_o), 32'd0);
        repeat (2) @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        seen_vld = 0;
        repeat (3) begin
            step();
            if (rsp_valid_o || wbm_cyc_o) seen_vld++;
        end
        check("mid_no_rsp", 32'(seen_vld), 32'd0);
        check("mid_rel_rdy", 32'(cmd_ready_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_host_master.md
WB_HOST_MASTER -- requirements
Module: wb_host_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum cycles with STB high and no ACK before abort (range 1..65535).
REQ-002 SHALL have ports wb_clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have ports wb_rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports cmd_valid_i / cmd_ready_o, input / output, 1 bit each: command handshake.
REQ-005 SHALL have ports cmd_we_i (in, 1), cmd_sel_i (in, 4), cmd_adr_i (in, 32) and cmd_dat_i (in, 32): command write-enable, byte select, address and write data.
REQ-006 SHALL have ports rsp_valid_o / rsp_ready_i, output / input, 1 bit each: response handshake.
REQ-007 SHALL have ports rsp_dat_o (out, 32): read data; rsp_err_o (out, 1): timeout flag.
REQ-008 SHALL have ports wbm_cyc_o, wbm_stb_o and wbm_we_o (out, 1 each); wbm_sel_o (out, 4); wbm_adr_o and wbm_dat_o (out, 32 each): Wishbone classic initiator outputs.
REQ-009 SHALL have ports wbm_ack_i (in, 1) and wbm_dat_i (in, 32): Wishbone responder inputs.
REQ-010 SHALL have port busy_o, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, BUS and RESP; all outputs SHALL be registered except cmd_ready_o and busy_o, which decode the state.
REQ-012 SHALL drive cmd_ready_o=1 only in IDLE.
- Command accepted on an edge where cmd_valid_i && cmd_ready_o.
- On acceptance: latch we/sel/adr/dat into the wbm_* registers, set cyc=stb=1, go IDLE->BUS.
REQ-013 SHALL hold wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o and wbm_dat_o stable throughout BUS.
REQ-014 SHALL, in BUS, on an edge with wbm_ack_i=1:
- clear cyc/stb;
- capture rsp_dat_o = wbm_dat_i when wbm_we_o=0, else 0;
- set rsp_err_o=0 and rsp_valid_o=1;
- go BUS->RESP.
REQ-015 SHALL, in RESP, hold rsp_valid_o=1 and rsp_dat_o/rsp_err_o stable until rsp_ready_i=1, then clear rsp_valid_o on that edge and go RESP->IDLE.
REQ-016 SHALL ignore wbm_ack_i outside BUS (stray ACK has no effect).
REQ-017 SHALL give minimum latency with a zero-wait responder (ACK in the first STB cycle): accept at edge N; STB high during cycle N..N+1; rsp_valid_o high after edge N+1.
REQ-018 SHALL accept a new command no earlier than the edge following the response handshake edge (no pipelining; one outstanding transaction).
REQ-019 SHALL clear wbm_we_o, wbm_sel_o, wbm_adr_o and wbm_dat_o to 0 when leaving BUS.

Reset
REQ-020 SHALL, while wb_rst_ni=0, asynchronously force:
- state=IDLE;
- all wbm_* outputs=0;
- rsp_valid_o=0, rsp_dat_o=0, rsp_err_o=0;
- timeout counter=0.
REQ-021 SHALL abandon any transaction in progress at reset, dropping CYC/STB immediately with no response issued.
REQ-022 SHALL make cmd_ready_o=1 in the first cycle after reset release.

Configuration
REQ-023 SHALL compile in a 16-bit timeout counter when macro WB_HOST_TIMEOUT_EN is defined:
- counter cleared on entry to BUS and incremented each BUS cycle without ACK;
- when it reaches TIMEOUT_CYCLES without ACK: clear cyc/stb, set rsp_dat_o=0, rsp_err_o=1, rsp_valid_o=1, go to RESP;
- ACK on the same edge as expiry takes priority (normal response, err=0).
REQ-024 SHALL, without WB_HOST_TIMEOUT_EN, omit the counter, wait in BUS indefinitely for ACK, and tie rsp_err_o to 0.

Verification
REQ-025 SHALL cover a write: cmd we=1 sel=F adr=0x3000_0000 dat=0x1234_5678, zero-wait responder -> bus shows exactly those values for 1 cycle; rsp_valid_o one edge after ACK; rsp_dat_o=0, rsp_err_o=0.
REQ-026 SHALL cover a read with 3 wait states, responder returns 0xCAFE_F00D -> STB high 4 cycles; rsp_dat_o=0xCAFE_F00D; bus fields stable throughout.
REQ-027 SHALL cover backpressure: rsp_ready_i=0 for 5 cycles -> rsp_valid_o and data held; cmd_ready_o=0 until the handshake, then 1 on the next cycle.
REQ-028 SHALL cover timeout (macro defined, TIMEOUT_CYCLES=8), responder never ACKs -> CYC drops after 8 STB cycles; rsp_err_o=1, rsp_dat_o=0. Same stimulus without the macro -> STB stays high for 1000 cycles with no response.
REQ-029 SHALL cover reset mid-BUS (drive wb_rst_ni=0 in the 2nd wait cycle) -> CYC/STB=0 asynchronously, no rsp_valid_o, cmd_ready_o=1 after release.
REQ-030 SHALL cover a stray ACK in IDLE, and ACK coincident with timeout expiry -> no state change; normal response with err=0.
